// File: rtl/ex_forward_ctrl_pkg.sv
// ex_forward_ctrl_pkg: shared types for the EX-stage forwarding / load-use controller.
//   lc3b_reg      : 3-bit GPR index (R0..R7, R0 is an ordinary register)
//   lc3b_fwd_tag  : per-stage producer tag {valid, dest, is_load}
//   lc3b_fwd_sel  : ALU operand forwarding select encoding
//   fwd_state_e   : controller FSM state
// Optional feature macro: FWD_STATS_EN (enables the saturating statistics counters).
package ex_forward_ctrl_pkg;

   typedef logic [2:0] lc3b_reg;

   typedef struct packed {
      logic    valid;
      lc3b_reg dest;
      logic    is_load;
   } lc3b_fwd_tag;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_MEM  = 2'b01,
      FWD_WB   = 2'b10
   } lc3b_fwd_sel;

   typedef enum logic [0:0] {
      StRun,
      StLuBubble
   } fwd_state_e;

   localparam int unsigned CountWidth = 16;

   localparam lc3b_fwd_tag BubbleTag = '{valid: 1'b0, dest: 3'd0, is_load: 1'b0};

   // Saturating increment used by the statistics counters.
   function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] val);
      return (val == {CountWidth{1'b1}}) ? val : val + 1'b1;
   endfunction

endpackage

// File: rtl/ex_forward_ctrl_if.sv
// ex_forward_ctrl_if: EX-stage fields into the forwarding controller and the
// forwarding selects / stall back to the EX datapath.
//   advance, ex_valid, ex_sr1/2, ex_uses_sr1/2, ex_dest, ex_load_regfile, ex_is_load
//       : driven by the pipeline (master)
//   alu_input_one_mux_sel, alu_input_two_mux_sel, stall
//       : driven by the controller (slave)
//   fwd_count, stall_count : statistics, present only with FWD_STATS_EN
interface ex_forward_ctrl_if;
   import ex_forward_ctrl_pkg::*;

   logic        advance;
   logic        ex_valid;
   lc3b_reg     ex_sr1;
   lc3b_reg     ex_sr2;
   logic        ex_uses_sr1;
   logic        ex_uses_sr2;
   lc3b_reg     ex_dest;
   logic        ex_load_regfile;
   logic        ex_is_load;
   lc3b_fwd_sel alu_input_one_mux_sel;
   lc3b_fwd_sel alu_input_two_mux_sel;
   logic        stall;
`ifdef FWD_STATS_EN
   logic [CountWidth-1:0] fwd_count;
   logic [CountWidth-1:0] stall_count;

   modport master (
      output advance, ex_valid, ex_sr1, ex_sr2, ex_uses_sr1, ex_uses_sr2,
             ex_dest, ex_load_regfile, ex_is_load,
      input  alu_input_one_mux_sel, alu_input_two_mux_sel, stall, fwd_count, stall_count
   );

   modport slave (
      input  advance, ex_valid, ex_sr1, ex_sr2, ex_uses_sr1, ex_uses_sr2,
             ex_dest, ex_load_regfile, ex_is_load,
      output alu_input_one_mux_sel, alu_input_two_mux_sel, stall, fwd_count, stall_count
   );
`else
   modport master (
      output advance, ex_valid, ex_sr1, ex_sr2, ex_uses_sr1, ex_uses_sr2,
             ex_dest, ex_load_regfile, ex_is_load,
      input  alu_input_one_mux_sel, alu_input_two_mux_sel, stall
   );

   modport slave (
      input  advance, ex_valid, ex_sr1, ex_sr2, ex_uses_sr1, ex_uses_sr2,
             ex_dest, ex_load_regfile, ex_is_load,
      output alu_input_one_mux_sel, alu_input_two_mux_sel, stall
   );
`endif

endinterface

// File: rtl/ex_forward_ctrl_fwd_operand_sel.sv
// fwd_operand_sel: resolves one ALU operand against the MEM and WB producer tags.
//   uses    : operand really read from the regfile (already qualified by ex_valid)
//   src     : source register index
//   mem_tag : producer currently in MEM
//   wb_tag  : producer currently in WB
//   sel     : forwarding select for this operand
//   hazard  : operand needs a load result that is still in MEM
module fwd_operand_sel
   import ex_forward_ctrl_pkg::*;
(
   input  logic        uses,
   input  lc3b_reg     src,
   input  lc3b_fwd_tag mem_tag,
   input  lc3b_fwd_tag wb_tag,
   output lc3b_fwd_sel sel,
   output logic        hazard
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_tag.valid && (mem_tag.dest == src);
   assign wb_hit  = wb_tag.valid && (wb_tag.dest == src);

   // MEM is checked first so the youngest producer wins; a load in MEM blocks
   // any older WB match on the same register.
   always_comb begin
      sel    = FWD_NONE;
      hazard = 1'b0;
      if (uses) begin
         if (mem_hit) begin
            if (mem_tag.is_load) begin
               hazard = 1'b1;
            end else begin
               sel = FWD_MEM;
            end
         end else if (wb_hit) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/ex_forward_ctrl.sv
// ex_forward_ctrl: EX-stage forwarding and load-use hazard controller.
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   bus        : ex_forward_ctrl_if.slave -- EX fields and advance in; operand selects
//                and stall out (plus fwd_count / stall_count with FWD_STATS_EN)
// Tracks the destination of the instructions in MEM and WB, drives both ALU operand
// selects, and inserts a single bubble when EX consumes a load still in MEM.
// Optional feature macro: FWD_STATS_EN (saturating 16-bit forward/stall counters).
module ex_forward_ctrl
   import ex_forward_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   ex_forward_ctrl_if.slave   bus
);

   lc3b_fwd_tag mem_tag_q, mem_tag_d;
   lc3b_fwd_tag wb_tag_q, wb_tag_d;
   fwd_state_e  state_q, state_d;

   lc3b_fwd_sel sel_one, sel_two;
   logic        hazard_one, hazard_two;
   logic        stall;

   fwd_operand_sel u_sel_one (
      .uses    (bus.ex_uses_sr1 & bus.ex_valid),
      .src     (bus.ex_sr1),
      .mem_tag (mem_tag_q),
      .wb_tag  (wb_tag_q),
      .sel     (sel_one),
      .hazard  (hazard_one)
   );

   fwd_operand_sel u_sel_two (
      .uses    (bus.ex_uses_sr2 & bus.ex_valid),
      .src     (bus.ex_sr2),
      .mem_tag (mem_tag_q),
      .wb_tag  (wb_tag_q),
      .sel     (sel_two),
      .hazard  (hazard_two)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:      if (bus.advance && stall) state_d = StLuBubble;
         StLuBubble: if (bus.advance) state_d = StRun;
         default:    state_d = StRun;
      endcase
   end

   // Output logic; in the bubble state the load has moved to WB, so no stall.
   always_comb begin
      stall = 1'b0;
      unique case (state_q)
         StRun:      stall = hazard_one | hazard_two;
         StLuBubble: stall = 1'b0;
         default:    stall = 1'b0;
      endcase
   end

   assign bus.stall                 = stall;
   assign bus.alu_input_one_mux_sel = sel_one;
   assign bus.alu_input_two_mux_sel = sel_two;

   // Producer tags; a stalled advance lets the load drain to WB and puts a bubble in MEM.
   always_comb begin
      mem_tag_d = mem_tag_q;
      wb_tag_d  = wb_tag_q;
      if (bus.advance) begin
         wb_tag_d = mem_tag_q;
         if (stall) begin
            mem_tag_d = BubbleTag;
         end else begin
            mem_tag_d.valid   = bus.ex_valid & bus.ex_load_regfile;
            mem_tag_d.dest    = bus.ex_dest;
            mem_tag_d.is_load = bus.ex_is_load;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_tag_q <= BubbleTag;
         wb_tag_q  <= BubbleTag;
      end else begin
         mem_tag_q <= mem_tag_d;
         wb_tag_q  <= wb_tag_d;
      end
   end

`ifdef FWD_STATS_EN
   logic [CountWidth-1:0] fwd_count_q, stall_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_count_q   <= '0;
         stall_count_q <= '0;
      end else if (bus.advance) begin
         if ((sel_one != FWD_NONE) || (sel_two != FWD_NONE)) begin
            fwd_count_q <= sat_inc(fwd_count_q);
         end
         if (stall) begin
            stall_count_q <= sat_inc(stall_count_q);
         end
      end
   end

   assign bus.fwd_count   = fwd_count_q;
   assign bus.stall_count = stall_count_q;
`endif

endmodule

// File: doc/ex_forward_ctrl.md
# ex_forward_ctrl

Forwarding and load-use hazard controller for the EX stage of the pipelined LC-3b core. It tracks the destination register of every instruction in MEM and WB, and drives the two ALU operand forwarding selects (`alu_input_one_mux_sel`, `alu_input_two_mux_sel`) consumed by the EX datapath. It also raises a one-bubble stall when an EX instruction needs a register that a load still in MEM will produce. It sits beside the EX datapath, fed by decoded EX-stage fields and the pipeline advance strobe.

## Interface
- No parameters; register index width fixed at 3 (8 GPRs).
- `clk`  in  1  pipeline clock
- `rst_n`  in  1  asynchronous active-low reset
- `advance`  in  1  pipeline registers latch this cycle (already includes memory-ready gating)
- `ex_valid`  in  1  EX holds a real instruction (not a bubble)
- `ex_sr1`, `ex_sr2`  in  3 each  EX source register indices
- `ex_uses_sr1`, `ex_uses_sr2`  in  1 each  operand read from regfile (sr2 low when alumux selects an immediate/offset)
- `ex_dest`  in  3  EX destination register
- `ex_load_regfile`  in  1  EX instruction writes regfile
- `ex_is_load`  in  1  EX result comes from data memory (LDR, LDB, LDI)
- `alu_input_one_mux_sel`, `alu_input_two_mux_sel`  out  2 each  00 = regfile/alumux, 01 = MEM result, 10 = WB result; 11 never driven
- `stall`  out  1  hold IF/ID/EX and inject a bubble into MEM
- `fwd_count`, `stall_count`  out  16 each  present only with FWD_STATS_EN

## Operation
- Internal tags, each {valid, dest[2:0], is_load}: `mem_tag` for MEM, `wb_tag` for WB.
- On `advance` with `stall`=0: `wb_tag` <= `mem_tag`; `mem_tag` <= {ex_valid & ex_load_regfile, ex_dest, ex_is_load}.
- On `advance` with `stall`=1: `wb_tag` <= `mem_tag`; `mem_tag` <= bubble (valid 0).
- `advance`=0: both tags hold.
- Per operand n (uses_srn & ex_valid required, else sel 00), checked in priority order:
  - mem_tag.valid & dest==srn & !is_load -> sel 01.
  - mem_tag.valid & dest==srn & is_load -> load-use hazard; sel 00.
  - wb_tag.valid & dest==srn -> sel 10.
  - otherwise -> sel 00.
- Youngest producer wins: a MEM match overrides a WB match on the same register.
- R0 is an ordinary register; no zero-register exclusion.
- FSM with two states:
  - RUN: `stall` = OR of both operands' hazard. On `advance` & `stall`, go to LU_BUBBLE.
  - LU_BUBBLE: `stall`=0 forced. The load is now in `wb_tag`, so the select resolves to 10. On `advance`, go to RUN.
- A dependent instruction stalls exactly one advancing cycle.

## Timing
- Selects and `stall` are combinational from inputs, tags and state; they are valid in the same cycle EX fields are presented.
- Tags, FSM and counters update on `posedge clk` only when `advance`=1.
- Reset (async, `rst_n` low): tags invalid, FSM=RUN, counters 0. Outputs then read sel 00/00, `stall` 0.
- Reset mid-stall: state and tags are discarded immediately, and outputs return to reset values in the same cycle.
- `advance`=0 while in LU_BUBBLE: remain in LU_BUBBLE, `stall` stays 0, selects remain stable.
- Both operands hazard on the same load: still a single bubble.

## Configuration
- `FWD_STATS_EN` defined:
  - `fwd_count` increments by 1 on each advancing cycle in which either select is non-zero.
  - `stall_count` increments on each advancing cycle with `stall`=1.
  - Both counters are 16-bit and saturate at 0xFFFF.
- `FWD_STATS_EN` undefined: the counter ports and logic are absent. Forwarding behaviour is identical.

## Structure
- Add to `lc3b_types`:
  - `lc3b_reg` (3 bits), if not already present.
  - `lc3b_fwd_tag` packed struct {valid, dest, is_load}.
  - `lc3b_fwd_sel` enum {FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10}.
  - FSM state enum.
- One sub-module, `fwd_operand_sel`, instanced twice. Inputs: uses, src, mem_tag, wb_tag. Outputs: sel, hazard.

## Test plan
- Reset: with `rst_n` low and any EX inputs, both sels are 00, `stall` is 0, and both counters read 0.
- ADD R1 then ADD R2,R1,R1 back to back: both sels 01, `stall` 0.
- ADD R3, one independent instruction, then AND R4,R3,#5 (`ex_uses_sr2`=0): sel1 10, sel2 00.
- LDR R5 followed by ADD R6,R5,R2:
  - Cycle 1: `stall` 1, sels 00.
  - Cycle 2: sel1 10, `stall` 0.
  - With FWD_STATS_EN, `stall_count`=1.
- ADD R1 in WB and LDR R1 in MEM, EX reads R1: `stall` 1. The MEM load must override the WB match.
- Stall with `advance`=0 for 3 cycles: `stall` stays 1 and tags are unchanged. Assert `rst_n` low mid-LU_BUBBLE: state returns to RUN and sels go to 00.
